shift_delay_line: RTL and testbench
===================================

# shift_delay_line

Parametrised, enable-gated shift-register delay line. It carries a data word and a valid tag through DEPTH registered stages. A run-time tap select chooses the output delay, and an occupancy counter tracks how many stages hold valid data. It is the general successor to the team's fixed two-stage register pair, used wherever a datapath needs a programmable-latency alignment delay.

## Interface
- DWIDTH, 8: data word width in bits.
- DEPTH, 4: number of register stages; must be ≥ 1.
- DLYW, 3: width of i_dly and o_cnt; must satisfy 2^DLYW > DEPTH.

Ports:
- i_clk  input  1  clock, all state updates on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_en  input  1  shift enable; 0 holds all stages.
- i_flush  input  1  synchronous clear of all stages; does not reset configuration.
- i_d  input  DWIDTH  data into stage 1.
- i_vld  input  1  valid tag accompanying i_d.
- i_dly  input  DLYW  tap select (delay in enabled cycles).
- o_q  output  DWIDTH  data at selected tap.
- o_vld  output  1  valid at selected tap.
- o_last  output  DWIDTH  data of stage DEPTH, which is the serial output, independent of i_dly.
- o_cnt  output  DLYW  number of stages currently holding valid = 1.

## Operation
- State: stages s[1..DEPTH], each holding {vld, data}, plus the o_cnt register.
- Update priority per rising edge: i_rst > i_flush > i_en > hold.
- i_rst=1: every s[k].data=0, s[k].vld=0, o_cnt=0.
- i_flush=1 (no reset): every s[k].data=0, s[k].vld=0, o_cnt=0. The i_d/i_vld presented that cycle are discarded, regardless of i_en.
- i_en=1:
  - s[1] ← {i_vld, i_d}; s[k] ← s[k-1] for k = 2..DEPTH.
  - All stages sample their predecessor's pre-edge value; true shift, no stage collapsing.
  - o_cnt ← o_cnt + i_vld − s[DEPTH].vld. Both terms are evaluated on pre-edge values, so the result is never below 0 and never above DEPTH.
- i_en=0: all stages and o_cnt hold.
- Invalid words (i_vld=0) still shift data normally; only the tag marks them.
- Tap mux (combinational from registered state and i_dly):
  - i_dly = 1..DEPTH: o_q = s[i_dly].data, o_vld = s[i_dly].vld.
  - i_dly = 0: bypass; o_q = i_d, o_vld = i_vld & i_en & ~i_flush & ~i_rst.
  - i_dly > DEPTH: clamped to DEPTH.
- o_last = s[DEPTH].data always.

## Timing
- Reset values, valid from the first edge with i_rst=1: o_q=0, o_vld=0, o_last=0, o_cnt=0. The exception is i_dly=0, where o_q follows i_d combinationally.
- Latency: for i_dly = N ≥ 1, a word sampled on enabled edge E appears at o_q after enabled edge E+N−1 and is stable until the next enabled edge. Disabled cycles add no latency count and simply stretch it.
- i_dly changes take effect in the same cycle; no pipeline flush is implied.
- Reset or flush asserted mid-stream loses all in-flight words at that edge. Shifting resumes on the first subsequent edge with i_en=1 and neither i_rst nor i_flush asserted.
- Simultaneous i_en=1 and i_flush=1: flush wins and o_cnt=0.
- Simultaneous valid entry and valid exit with o_cnt=DEPTH: o_cnt stays at DEPTH, with no overflow or wrap.

## Test plan
- Reset: i_rst=1 for 2 edges with i_en=1, i_vld=1, i_d=0xAA, i_dly=2 → o_q=0x00, o_vld=0, o_cnt=0 after each edge.
- Delay: i_dly=2; drive 0x11, 0x22, 0x33 valid on enabled edges 1, 2, 3 → after edge 2, o_q=0x11 and o_vld=1; after edge 3, o_q=0x22; o_last=0x11 after edge 4.
- Stall: mid-stream, i_en=0 for 3 cycles → o_q, o_vld, o_last, o_cnt frozen. After re-enable, the sequence continues with no lost or duplicated word.
- Flush: stages hold 4 valid words; assert i_flush=1, i_en=1, i_vld=1, i_d=0x55 → next cycle o_cnt=0 and all o_vld=0 for every i_dly; 0x55 never appears.
- Occupancy: 6 consecutive valid words then invalid words, i_en=1 throughout → o_cnt sequence 1, 2, 3, 4, 4, 4, 3, 2, 1, 0.
- Tap range:
  - i_dly=0 with i_d=0x7E, i_vld=1, i_en=1 → o_q=0x7E and o_vld=1 in the same cycle.
  - i_dly=7 → o_q equals s[4].data (identical to i_dly=4).

Source files
------------

// File: rtl/shift_delay_line_if.sv
// Bus bundle for shift_delay_line: shift control, data/valid in, tap select,
// and the tap, serial and occupancy outputs.
interface shift_delay_line_if #(
   parameter int DWIDTH = 8,
   parameter int DLYW   = 3
) ();
   logic              i_en;
   logic              i_flush;
   logic [DWIDTH-1:0] i_d;
   logic              i_vld;
   logic [DLYW-1:0]   i_dly;
   logic [DWIDTH-1:0] o_q;
   logic              o_vld;
   logic [DWIDTH-1:0] o_last;
   logic [DLYW-1:0]   o_cnt;

   modport master (
      output i_en, i_flush, i_d, i_vld, i_dly,
      input  o_q, o_vld, o_last, o_cnt
   );

   modport slave (
      input  i_en, i_flush, i_d, i_vld, i_dly,
      output o_q, o_vld, o_last, o_cnt
   );
endinterface

// File: rtl/shift_delay_line.sv
// Enable-gated DEPTH-stage delay line for a data word plus valid tag, with a
// run-time tap select and a count of stages holding valid words.
module shift_delay_line #(
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 4,
   parameter int DLYW   = 3
) (
   input  logic               i_clk,
   input  logic               i_rst,
   shift_delay_line_if.slave  bus
);

   // Index 0 is stage 1 (newest), index DEPTH-1 is the serial output stage.
   logic [DEPTH-1:0][DWIDTH-1:0] data_r;
   logic [DEPTH-1:0]             vld_r;
   logic [DLYW-1:0]              cnt_r;

   logic [DLYW-1:0]   cnt_next_s;
   logic [DLYW-1:0]   sel_s;
   logic [DWIDTH-1:0] q_s;
   logic              q_vld_s;

   // Entry and exit terms both use pre-edge values, so this stays within 0..DEPTH.
   assign cnt_next_s = cnt_r
                     + {{(DLYW-1){1'b0}}, bus.i_vld}
                     - {{(DLYW-1){1'b0}}, vld_r[DEPTH-1]};

   // Stage registers and occupancy counter: reset > flush > shift > hold.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         data_r <= '0;
         vld_r  <= '0;
         cnt_r  <= '0;
      end else if (bus.i_flush) begin
         data_r <= '0;
         vld_r  <= '0;
         cnt_r  <= '0;
      end else if (bus.i_en) begin
         data_r[0] <= bus.i_d;
         vld_r[0]  <= bus.i_vld;
         for (int k = 1; k < DEPTH; k++) begin
            data_r[k] <= data_r[k-1];
            vld_r[k]  <= vld_r[k-1];
         end
         cnt_r <= cnt_next_s;
      end else begin
         data_r <= data_r;
         vld_r  <= vld_r;
         cnt_r  <= cnt_r;
      end
   end

   // Tap select clamp: anything past the last stage reads the last stage.
   always_comb begin
      sel_s = bus.i_dly;
      if (bus.i_dly > DLYW'(DEPTH)) begin
         sel_s = DLYW'(DEPTH);
      end else begin
         sel_s = bus.i_dly;
      end
   end

   // Tap mux; a zero tap bypasses the stages and only flags words that would be accepted.
   always_comb begin
      q_s     = bus.i_d;
      q_vld_s = bus.i_vld & bus.i_en & ~bus.i_flush & ~i_rst;
      if (sel_s == {DLYW{1'b0}}) begin
         q_s     = bus.i_d;
         q_vld_s = bus.i_vld & bus.i_en & ~bus.i_flush & ~i_rst;
      end else begin
         q_s     = data_r[DEPTH-1];
         q_vld_s = vld_r[DEPTH-1];
         for (int k = 0; k < DEPTH; k++) begin
            q_s     = (sel_s == DLYW'(k + 1)) ? data_r[k] : q_s;
            q_vld_s = (sel_s == DLYW'(k + 1)) ? vld_r[k]  : q_vld_s;
         end
      end
   end

   assign bus.o_q    = q_s;
   assign bus.o_vld  = q_vld_s;
   assign bus.o_last = data_r[DEPTH-1];
   assign bus.o_cnt  = cnt_r;

endmodule

// File: tb/tb_shift_delay_line.sv
// Directed self-checking bench for shift_delay_line (DWIDTH=8, DEPTH=4, DLYW=3).
module tb_shift_delay_line;

   logic i_clk = 1'b0;
   logic i_rst;
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   shift_delay_line_if #(.DWIDTH(8), .DLYW(3)) bus ();

   shift_delay_line #(.DWIDTH(8), .DEPTH(4), .DLYW(3)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_flush();
      bus.i_flush = 1'b1;
      tick();
      bus.i_flush = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; bus.i_en = 1'b1; bus.i_vld = 1'b1; bus.i_d = 8'hAA;
      bus.i_dly = 3'd2; bus.i_flush = 1'b0;
      for (int e = 0; e < 2; e++) begin
         tick();
         total_cnt++;
         if (bus.o_q !== 8'h00) $display("FAIL reset_q edge%0d got %h want 00", e, bus.o_q);
         else pass_cnt++;
         total_cnt++;
         if (bus.o_vld !== 1'b0) $display("FAIL reset_vld edge%0d got %b want 0", e, bus.o_vld);
         else pass_cnt++;
         total_cnt++;
         if (bus.o_cnt !== 3'd0) $display("FAIL reset_cnt edge%0d got %0d want 0", e, bus.o_cnt);
         else pass_cnt++;
         total_cnt++;
         if (bus.o_last !== 8'h00) $display("FAIL reset_last edge%0d got %h want 00", e, bus.o_last);
         else pass_cnt++;
      end
      i_rst = 1'b0;
   endtask

   task automatic test_delay();
      logic [7:0] din [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic [7:0] wq  [4]  = '{8'h00, 8'h11, 8'h22, 8'h33};
      logic       wv  [4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
      do_flush();
      bus.i_dly = 3'd2; bus.i_en = 1'b1; bus.i_vld = 1'b1;
      for (int e = 0; e < 4; e++) begin
         bus.i_d = din[e];
         tick();
         total_cnt++;
         if (bus.o_q !== wq[e]) $display("FAIL delay_q edge%0d got %h want %h", e + 1, bus.o_q, wq[e]);
         else pass_cnt++;
         total_cnt++;
         if (bus.o_vld !== wv[e]) $display("FAIL delay_vld edge%0d got %b want %b", e + 1, bus.o_vld, wv[e]);
         else pass_cnt++;
      end
      total_cnt++;
      if (bus.o_last !== 8'h11) $display("FAIL delay_last got %h want 11", bus.o_last);
      else pass_cnt++;
      total_cnt++;
      if (bus.o_cnt !== 3'd4) $display("FAIL delay_cnt got %0d want 4", bus.o_cnt);
      else pass_cnt++;
   endtask

   task automatic test_stall();
      do_flush();
      bus.i_dly = 3'd3; bus.i_en = 1'b1; bus.i_vld = 1'b1;
      bus.i_d = 8'hA1; tick();
      bus.i_d = 8'hA2; tick();
      bus.i_d = 8'hA3; tick();
      bus.i_en = 1'b0; bus.i_d = 8'hEE;
      for (int c = 0; c < 3; c++) begin
         tick();
         total_cnt++;
         if (bus.o_q !== 8'hA1 || bus.o_vld !== 1'b1)
            $display("FAIL stall_tap cyc%0d got %h/%b want a1/1", c, bus.o_q, bus.o_vld);
         else pass_cnt++;
         total_cnt++;
         if (bus.o_last !== 8'h00 || bus.o_cnt !== 3'd3)
            $display("FAIL stall_hold cyc%0d got last=%h cnt=%0d want 00/3", c, bus.o_last, bus.o_cnt);
         else pass_cnt++;
      end
      bus.i_en = 1'b1; bus.i_d = 8'hA4; tick();
      total_cnt++;
      if (bus.o_q !== 8'hA2 || bus.o_last !== 8'hA1 || bus.o_cnt !== 3'd4)
         $display("FAIL stall_resume1 got q=%h last=%h cnt=%0d want a2/a1/4", bus.o_q, bus.o_last, bus.o_cnt);
      else pass_cnt++;
      bus.i_d = 8'hA5; tick();
      total_cnt++;
      if (bus.o_q !== 8'hA3 || bus.o_last !== 8'hA2 || bus.o_cnt !== 3'd4)
         $display("FAIL stall_resume2 got q=%h last=%h cnt=%0d want a3/a2/4", bus.o_q, bus.o_last, bus.o_cnt);
      else pass_cnt++;
   endtask

   task automatic test_flush();
      bus.i_flush = 1'b1; bus.i_en = 1'b1; bus.i_vld = 1'b1; bus.i_d = 8'h55;
      tick();
      bus.i_flush = 1'b0; bus.i_en = 1'b0; bus.i_d = 8'h00;
      total_cnt++;
      if (bus.o_cnt !== 3'd0 || bus.o_last !== 8'h00)
         $display("FAIL flush_state got cnt=%0d last=%h want 0/00", bus.o_cnt, bus.o_last);
      else pass_cnt++;
      for (int t = 0; t < 8; t++) begin
         bus.i_dly = 3'(t);
         #1;
         total_cnt++;
         if (bus.o_vld !== 1'b0 || bus.o_q !== 8'h00)
            $display("FAIL flush_tap dly%0d got %h/%b want 00/0", t, bus.o_q, bus.o_vld);
         else pass_cnt++;
      end
      bus.i_en = 1'b1; bus.i_vld = 1'b0; bus.i_dly = 3'd4;
      tick();
      total_cnt++;
      if (bus.o_last !== 8'h00 || bus.o_q !== 8'h00)
         $display("FAIL flush_discard got last=%h q=%h want 00/00", bus.o_last, bus.o_q);
      else pass_cnt++;
   endtask

   task automatic test_occupancy();
      logic [2:0] wcnt [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      logic [7:0] wlast;
      do_flush();
      bus.i_en = 1'b1; bus.i_dly = 3'd4;
      for (int e = 1; e <= 10; e++) begin
         bus.i_vld = (e <= 6) ? 1'b1 : 1'b0;
         bus.i_d   = 8'(8'h60 + e);
         tick();
         total_cnt++;
         if (bus.o_cnt !== wcnt[e-1]) $display("FAIL occ_cnt edge%0d got %0d want %0d", e, bus.o_cnt, wcnt[e-1]);
         else pass_cnt++;
         if (e >= 4) begin
            wlast = 8'(8'h60 + e - 3);
            total_cnt++;
            if (bus.o_last !== wlast) $display("FAIL occ_last edge%0d got %h want %h", e, bus.o_last, wlast);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_tap_range();
      // Stages now hold 6a,69,68,67 (all invalid) from the occupancy run.
      bus.i_dly = 3'd0; bus.i_d = 8'h7E; bus.i_vld = 1'b1; bus.i_en = 1'b1; bus.i_flush = 1'b0;
      #1;
      total_cnt++;
      if (bus.o_q !== 8'h7E || bus.o_vld !== 1'b1)
         $display("FAIL tap_bypass got %h/%b want 7e/1", bus.o_q, bus.o_vld);
      else pass_cnt++;
      bus.i_en = 1'b0;
      #1;
      total_cnt++;
      if (bus.o_vld !== 1'b0) $display("FAIL tap_bypass_dis got %b want 0", bus.o_vld);
      else pass_cnt++;
      tick();
      bus.i_dly = 3'd7;
      #1;
      total_cnt++;
      if (bus.o_q !== 8'h67) $display("FAIL tap_clamp7 got %h want 67", bus.o_q);
      else pass_cnt++;
      bus.i_dly = 3'd4;
      #1;
      total_cnt++;
      if (bus.o_q !== 8'h67) $display("FAIL tap_dly4 got %h want 67", bus.o_q);
      else pass_cnt++;
      bus.i_dly = 3'd1;
      #1;
      total_cnt++;
      if (bus.o_q !== 8'h6A) $display("FAIL tap_dly1 got %h want 6a", bus.o_q);
      else pass_cnt++;
   endtask

   initial begin
      i_rst = 1'b1;
      bus.i_en = 1'b0; bus.i_flush = 1'b0; bus.i_d = 8'h00; bus.i_vld = 1'b0; bus.i_dly = 3'd0;
      #2;
      test_reset();
      test_delay();
      test_stall();
      test_flush();
      test_occupancy();
      test_tap_range();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
